// File: rtl/rsp_read_ctrl.sv
// SD command-response receiver: waits for the start bit on CMD, shifts in a 48/136-bit
// frame, strobes an external serial CRC7 unit and reports payload plus error flags.
module rsp_read_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         sd_clk_i,
  input  logic         rst_i,
  input  logic         rsp_expect_i,
  input  logic         rsp_long_i,
  input  logic         rsp_crc_en_i,
  input  logic         cmd_i,
  output logic         busy_o,
  output logic         crc_start_o,
  output logic         crc_end_o,
  output logic         crc_dat_o,
  input  logic [6:0]   crc7_i,
  output logic         rsp_valid_o,
  output logic [119:0] rsp_data_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  output logic         timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    bit_cnt;
  logic          is_long, crc_en;
  logic [6:0]    rx_crc;
  logic [1:0]    dly;
  logic          last_bit, data_bit, crc_bit, tmo_hit;

  assign crc_dat_o = dly[1];

  always_comb begin
    last_bit = bit_cnt == (is_long ? 8'd135 : 8'd47);
    data_bit = is_long ? (bit_cnt >= 8'd8  && bit_cnt <= 8'd127)
                       : (bit_cnt >= 8'd2  && bit_cnt <= 8'd39);
    crc_bit  = is_long ? (bit_cnt >= 8'd128 && bit_cnt <= 8'd134)
                       : (bit_cnt >= 8'd40  && bit_cnt <= 8'd46);
    tmo_hit  = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  end

  always_comb begin
    state_nxt   = state;
    busy_o      = state != IDLE;
    rsp_valid_o = state == DONE;
    crc_start_o = 1'b0;
    crc_end_o   = 1'b0;
    case (state)
      IDLE:       if (rsp_expect_i) state_nxt = WAIT_START;
      WAIT_START: begin
        // a start bit on the final timeout cycle still wins
        if (!cmd_i) begin
          state_nxt   = RECEIVE;
          crc_start_o = crc_en && !is_long;
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      RECEIVE: begin
        crc_start_o = crc_en && is_long && bit_cnt == 8'd8;
        crc_end_o   = crc_en && bit_cnt == (is_long ? 8'd129 : 8'd41);
        if (last_bit) state_nxt = DONE;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      is_long     <= 1'b0;
      crc_en      <= 1'b0;
      rx_crc      <= '0;
      dly         <= 2'b11;
      rsp_data_o  <= '0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      dly   <= {dly[0], cmd_i};
      case (state)
        IDLE: if (rsp_expect_i) begin
          is_long     <= rsp_long_i;
          crc_en      <= rsp_crc_en_i;
          tmo_cnt     <= '0;
          bit_cnt     <= '0;
          rx_crc      <= '0;
          rsp_data_o  <= '0;
          crc_err_o   <= 1'b0;
          frame_err_o <= 1'b0;
          timeout_o   <= 1'b0;
        end
        WAIT_START: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!cmd_i)       bit_cnt   <= 8'd1;
          else if (tmo_hit) timeout_o <= 1'b1;
        end
        RECEIVE: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (data_bit) rsp_data_o <= {rsp_data_o[118:0], cmd_i};
          if (crc_bit)  rx_crc     <= {rx_crc[5:0], cmd_i};
          if (bit_cnt == 8'd1 && cmd_i) frame_err_o <= 1'b1;
          // rx_crc is complete and crc7_i settled by the end bit
          if (last_bit) begin
            if (!cmd_i) frame_err_o <= 1'b1;
            crc_err_o <= crc_en && (rx_crc != crc7_i);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_read_ctrl.sv
// Randomized scoreboard bench for rsp_read_ctrl with a behavioural CRC7 unit on the strobes.
module tb_rsp_read_ctrl;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_i, rsp_expect_i, rsp_long_i, rsp_crc_en_i, cmd_i;
  logic         busy_o, crc_start_o, crc_end_o, crc_dat_o;
  logic [6:0]   crc7_i = '0;
  logic         rsp_valid_o, crc_err_o, frame_err_o, timeout_o;
  logic [119:0] rsp_data_o;

  rsp_read_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .sd_clk_i(clk), .rst_i(rst_i), .rsp_expect_i(rsp_expect_i), .rsp_long_i(rsp_long_i),
    .rsp_crc_en_i(rsp_crc_en_i), .cmd_i(cmd_i), .busy_o(busy_o), .crc_start_o(crc_start_o),
    .crc_end_o(crc_end_o), .crc_dat_o(crc_dat_o), .crc7_i(crc7_i), .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o), .crc_err_o(crc_err_o), .frame_err_o(frame_err_o),
    .timeout_o(timeout_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    crc_step = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc_bits(input logic [135:0] f, input int lo, input int hi);
    logic [6:0] c = '0;
    for (int k = lo; k <= hi; k++) c = crc_step(c, f[k]);
    return c;
  endfunction

  typedef struct {
    int           vcyc;
    logic [119:0] data;
    bit           crc_err, frame_err, tmo, cen;
    int           st, en;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: derives the whole expected response from the frame bits.
  function automatic exp_t ref_model(input bit lng, input bit cen, input bit tmo,
                                     input int d, input logic [135:0] f, input int e);
    exp_t x;
    int s, len, lo, hi;
    logic [6:0] rx;
    x.data = '0; x.crc_err = 0; x.frame_err = 0; x.tmo = tmo; x.cen = 0; x.st = -1; x.en = -1;
    if (tmo) begin
      x.vcyc = e + TMO + 1;
      return x;
    end
    len = lng ? 136 : 48;
    s   = e + 1 + d;
    lo  = lng ? 8 : 0;
    hi  = lng ? 127 : 39;
    x.vcyc = s + len;
    if (lng) for (int i = 0; i < 120; i++) x.data[119-i] = f[8+i];
    else     for (int i = 0; i < 38;  i++) x.data[37-i]  = f[2+i];
    for (int i = 0; i < 7; i++) rx[6-i] = f[len-8+i];
    x.cen       = cen;
    x.crc_err   = cen && (rx != crc_bits(f, lo, hi));
    x.frame_err = f[1] || !f[len-1];
    x.st        = lng ? s + 8 : s;
    x.en        = lng ? s + 129 : s + 41;
    return x;
  endfunction

  function automatic logic [135:0] mk_short(input logic [39:0] hdr);
    logic [135:0] f = '0;
    logic [6:0] c;
    for (int k = 0; k < 40; k++) f[k] = hdr[39-k];
    c = crc_bits(f, 0, 39);
    for (int i = 0; i < 7; i++) f[40+i] = c[6-i];
    f[47] = 1'b1;
    return f;
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] cid);
    logic [135:0] f = '0;
    logic [7:0] h = 8'h3F;
    logic [6:0] c;
    for (int k = 0; k < 8; k++)   f[k]   = h[7-k];
    for (int k = 0; k < 120; k++) f[8+k] = cid[119-k];
    c = crc_bits(f, 8, 127);
    for (int i = 0; i < 7; i++) f[128+i] = c[6-i];
    f[135] = 1'b1;
    return f;
  endfunction

  // Behavioural CRC7 unit driven purely by the DUT strobes.
  logic [6:0] acc = '0;
  int  pend = 0;
  bit  act = 0;
  always @(negedge clk) begin
    if (rst_i) begin
      act = 0; pend = 0;
    end else begin
      if (crc_start_o) begin acc = '0; pend = 2; act = 0; end
      else if (pend > 0) begin pend--; if (pend == 0) act = 1; end
      if (act) begin
        acc = crc_step(acc, crc_dat_o);
        if (crc_end_o) begin act = 0; crc7_i = acc; end
      end
    end
  end

  // Monitor: strobe bookkeeping and scoreboard compare on every rsp_valid_o.
  int nst = 0, nen = 0, st_c = -1, en_c = -1;
  always @(negedge clk) begin
    exp_t x;
    if (crc_start_o) begin nst++; st_c = cyc; end
    if (crc_end_o)   begin nen++; en_c = cyc; end
    if (rsp_valid_o && !rst_i) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        x = exp_q.pop_front();
        chk("valid_cycle", cyc, x.vcyc);
        chk("rsp_data",    rsp_data_o, x.data);
        chk("crc_err",     crc_err_o, x.crc_err);
        chk("frame_err",   frame_err_o, x.frame_err);
        chk("timeout",     timeout_o, x.tmo);
        chk("busy_at_valid", busy_o, 1);
        chk("crc_start_cnt", nst, x.cen ? 1 : 0);
        chk("crc_end_cnt",   nen, x.cen ? 1 : 0);
        if (x.cen) begin
          chk("crc_start_cyc", st_c, x.st);
          chk("crc_end_cyc",   en_c, x.en);
        end
      end
      nst = 0; nen = 0;
    end
    if (rst_i) begin nst = 0; nen = 0; end
  end

  // One response: expect at cycle e, d idle cycles, frame, then the DONE cycle.
  task automatic run_rsp(input bit lng, input bit cen, input int d, input logic [135:0] f,
                         input bit tmo, input int abort_at, input bit poke);
    int e, len, total, k;
    len = lng ? 136 : 48;
    @(posedge clk); #1;
    rsp_expect_i = 1; rsp_long_i = lng; rsp_crc_en_i = cen; cmd_i = 1; e = cyc;
    chk("busy_before_accept", busy_o, 0);
    if (abort_at < 0) exp_q.push_back(ref_model(lng, cen, tmo, d, f, e));
    total = tmo ? TMO + 1 : d + len + 1;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      rsp_expect_i = 0; rsp_long_i = lng; rsp_crc_en_i = cen;
      if (c == 1) chk("busy_after_accept", busy_o, 1);
      k = c - 1 - d;
      cmd_i = (!tmo && k >= 0 && k < len) ? f[k] : 1'b1;
      if (poke && k == 10) begin rsp_expect_i = 1; rsp_long_i = !lng; rsp_crc_en_i = !cen; end
      if (abort_at >= 0 && k == abort_at) begin
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0; cmd_i = 1;
        chk("busy_after_reset", busy_o, 0);
        chk("valid_after_reset", rsp_valid_o, 0);
        break;
      end
    end
  endtask

  initial begin
    logic [135:0] f;
    logic [6:0] c;
    bit lng, cen, tmo;
    rst_i = 1; rsp_expect_i = 0; rsp_long_i = 0; rsp_crc_en_i = 0; cmd_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_data", rsp_data_o, 0);
    chk("rst_flags", {crc_err_o, frame_err_o, timeout_o}, 0);
    chk("rst_strobes", {crc_start_o, crc_end_o}, 0);
    chk("rst_crc_dat", crc_dat_o, 1);

    f = mk_short({2'b00, 6'h37, 32'h120});
    run_rsp(0, 1, 4, f, 0, -1, 0);
    f[20] = ~f[20];
    run_rsp(0, 1, 4, f, 0, -1, 0);
    f = mk_short({2'b00, 6'h3F, 32'h80FF8000});
    for (int i = 40; i < 48; i++) f[i] = 1'b1;
    run_rsp(0, 0, 2, f, 0, -1, 0);
    f = mk_long(120'h23456789ABCDEF0123456789ABCDEF);
    run_rsp(1, 1, 6, f, 0, -1, 0);
    run_rsp(0, 1, 0, f, 1, -1, 0);
    f = mk_short({2'b00, 6'h11, 32'hDEADBEEF});
    run_rsp(0, 1, 63, f, 0, -1, 0);
    run_rsp(0, 1, 3, f, 0, 20, 0);
    repeat (5) @(posedge clk);
    run_rsp(0, 1, 3, f, 0, -1, 1);
    run_rsp(0, 1, 1, '0, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      lng = ($urandom % 3) == 0;
      cen = ($urandom % 4) != 0;
      tmo = ($urandom % 10) == 0;
      for (int i = 0; i < 136; i++) f[i] = 1'($urandom);
      f[0] = 1'b0;
      f[1] = ($urandom % 8) == 0;
      if (lng) begin
        c = crc_bits(f, 8, 127);
        if ($urandom % 5 != 0) for (int i = 0; i < 7; i++) f[128+i] = c[6-i];
        f[135] = ($urandom % 8) != 0;
      end else begin
        c = crc_bits(f, 0, 39);
        if ($urandom % 5 != 0) for (int i = 0; i < 7; i++) f[40+i] = c[6-i];
        f[47] = ($urandom % 8) != 0;
      end
      run_rsp(lng, cen, int'($urandom_range(0, 63)), f, tmo, -1, ($urandom % 6) == 0);
    end

    for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
